// File: rtl/ctrl_sequencer_if.sv
// Control bundle between the sequencer and the CPU datapath/memory.
// The master modport is the sequencer side; the slave modport is the datapath side.
interface ctrl_sequencer_if #(
   parameter int OP_W  = 4,
   parameter int CNT_W = 18
);
   logic [OP_W-1:0]  opcode;
   logic             zero_flag;
   logic             mem_ready;
   logic             pc_en;
   logic             pc_sel;
   logic             ir_en;
   logic             addr_sel;
   logic             mem_rd;
   logic             mem_wr;
   logic             rf_we;
   logic             wb_sel;
   logic             halted;
   logic [2:0]       state;
   logic [CNT_W-1:0] retired;

   modport master (
      input  opcode, zero_flag, mem_ready,
      output pc_en, pc_sel, ir_en, addr_sel, mem_rd, mem_wr, rf_we, wb_sel,
             halted, state, retired
   );

   modport slave (
      output opcode, zero_flag, mem_ready,
      input  pc_en, pc_sel, ir_en, addr_sel, mem_rd, mem_wr, rf_we, wb_sel,
             halted, state, retired
   );
endinterface

// File: rtl/ctrl_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: drives datapath load enables and
// memory strobes from the current state, and counts retired instructions.
module ctrl_sequencer #(
   parameter int OP_W  = 4,
   parameter int CNT_W = 18
) (
   input logic              clk,
   input logic              reset,
   ctrl_sequencer_if.master bus
);
   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_HALT   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      C_NOP = 3'd0,
      C_ALU = 3'd1,
      C_LD  = 3'd2,
      C_ST  = 3'd3,
      C_BEQ = 3'd4,
      C_JMP = 3'd5,
      C_HLT = 3'd6
   } op_class_t;

   state_t           state_r;
   state_t           state_nxt_s;
   op_class_t        cls_s;
   logic [3:0]       op_s;
   logic [CNT_W-1:0] retired_r;
   logic             retire_s;
   logic             pc_en_s, pc_sel_s, ir_en_s, addr_sel_s;
   logic             mem_rd_s, mem_wr_s, rf_we_s, wb_sel_s, halted_s;

   assign op_s = bus.opcode[OP_W-1:OP_W-4];

   // Opcode class decode
   always_comb begin
      cls_s = C_NOP;
      case (op_s)
         4'b0000:                            cls_s = C_NOP;
         4'b0001, 4'b0010, 4'b0011, 4'b0100,
         4'b0101, 4'b0110, 4'b0111:          cls_s = C_ALU;
         4'b1000:                            cls_s = C_LD;
         4'b1001:                            cls_s = C_ST;
         4'b1010:                            cls_s = C_BEQ;
         4'b1011:                            cls_s = C_JMP;
         4'b1111:                            cls_s = C_HLT;
         default:                            cls_s = C_NOP;
      endcase
   end

   // Next-state and combinational control outputs
   always_comb begin
      state_nxt_s = state_r;
      pc_en_s     = 1'b0;
      pc_sel_s    = 1'b0;
      ir_en_s     = 1'b0;
      addr_sel_s  = 1'b0;
      mem_rd_s    = 1'b0;
      mem_wr_s    = 1'b0;
      rf_we_s     = 1'b0;
      wb_sel_s    = 1'b0;
      halted_s    = 1'b0;
      if (reset) begin
         state_nxt_s = S_FETCH;
      end else begin
         case (state_r)
            S_FETCH: begin
               mem_rd_s = 1'b1;
               if (bus.mem_ready) begin
                  ir_en_s     = 1'b1;
                  pc_en_s     = 1'b1;
                  state_nxt_s = S_DECODE;
               end else begin
                  state_nxt_s = S_FETCH;
               end
            end
            S_DECODE: begin
               if (cls_s == C_NOP)      state_nxt_s = S_FETCH;
               else if (cls_s == C_HLT) state_nxt_s = S_HALT;
               else                     state_nxt_s = S_EXEC;
            end
            S_EXEC: begin
               case (cls_s)
                  C_ALU:       state_nxt_s = S_WB;
                  C_LD, C_ST:  state_nxt_s = S_MEM;
                  C_BEQ: begin
                     pc_sel_s    = 1'b1;
                     pc_en_s     = bus.zero_flag;
                     state_nxt_s = S_FETCH;
                  end
                  C_JMP: begin
                     pc_sel_s    = 1'b1;
                     pc_en_s     = 1'b1;
                     state_nxt_s = S_FETCH;
                  end
                  default:     state_nxt_s = S_FETCH;
               endcase
            end
            S_MEM: begin
               addr_sel_s = 1'b1;
               // A store completes the instruction; a load still needs write-back.
               if (cls_s == C_LD) begin
                  mem_rd_s    = 1'b1;
                  state_nxt_s = bus.mem_ready ? S_WB : S_MEM;
               end else if (cls_s == C_ST) begin
                  mem_wr_s    = 1'b1;
                  state_nxt_s = bus.mem_ready ? S_FETCH : S_MEM;
               end else begin
                  state_nxt_s = S_FETCH;
               end
            end
            S_WB: begin
               rf_we_s     = 1'b1;
               wb_sel_s    = (cls_s == C_LD);
               state_nxt_s = S_FETCH;
            end
            S_HALT: begin
               halted_s    = 1'b1;
               state_nxt_s = S_HALT;
            end
            default: state_nxt_s = S_FETCH;
         endcase
      end
   end

   // Retire strobe: instruction completion, including the final HLT
   always_comb begin
      retire_s = 1'b0;
      if (reset) begin
         retire_s = 1'b0;
      end else if (state_nxt_s == S_FETCH) begin
         retire_s = (state_r inside {S_DECODE, S_EXEC, S_MEM, S_WB});
      end else if (state_nxt_s == S_HALT) begin
         retire_s = (state_r == S_DECODE);
      end else begin
         retire_s = 1'b0;
      end
   end

   // State register and wrapping retired-instruction counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= S_FETCH;
         retired_r <= {CNT_W{1'b0}};
      end else begin
         state_r   <= state_nxt_s;
         retired_r <= retired_r + {{(CNT_W-1){1'b0}}, retire_s};
      end
   end

   assign bus.pc_en    = pc_en_s;
   assign bus.pc_sel   = pc_sel_s;
   assign bus.ir_en    = ir_en_s;
   assign bus.addr_sel = addr_sel_s;
   assign bus.mem_rd   = mem_rd_s;
   assign bus.mem_wr   = mem_wr_s;
   assign bus.rf_we    = rf_we_s;
   assign bus.wb_sel   = wb_sel_s;
   assign bus.halted   = halted_s;
   assign bus.state    = state_r;
   assign bus.retired  = retired_r;
endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: per-instruction expected cycle traces,
// a directed latency table, random instruction streams and reset/halt/wrap corners.
module tb_ctrl_sequencer;
   localparam int OP_W  = 4;
   localparam int CNT_W = 10;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   localparam logic [8:0] O_PCEN  = 9'b100000000;
   localparam logic [8:0] O_PCSEL = 9'b010000000;
   localparam logic [8:0] O_IREN  = 9'b001000000;
   localparam logic [8:0] O_ADDR  = 9'b000100000;
   localparam logic [8:0] O_RD    = 9'b000010000;
   localparam logic [8:0] O_WR    = 9'b000001000;
   localparam logic [8:0] O_RFWE  = 9'b000000100;
   localparam logic [8:0] O_WBSEL = 9'b000000010;
   localparam logic [8:0] O_HALT  = 9'b000000001;

   localparam int K_NOP = 0, K_ALU = 1, K_LD = 2, K_ST = 3, K_BEQ = 4, K_JMP = 5, K_HLT = 6;

   typedef struct {
      logic             rdy;
      logic             zf;
      logic [3:0]       op;
      logic [2:0]       st;
      logic [8:0]       outs;
      logic [CNT_W-1:0] ret;
   } cyc_t;

   typedef struct {
      logic [3:0] op;
      int         fw;
      int         mw;
      logic       zf;
      int         lat;
      int         pcen;
      int         rfwe;
      int         wr;
      int         rd;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ctrl_sequencer_if #(.OP_W(OP_W), .CNT_W(CNT_W)) bus_i ();
   ctrl_sequencer #(.OP_W(OP_W), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus_i));

   logic [8:0] outs_w;
   assign outs_w = {bus_i.pc_en, bus_i.pc_sel, bus_i.ir_en, bus_i.addr_sel, bus_i.mem_rd,
                    bus_i.mem_wr, bus_i.rf_we, bus_i.wb_sel, bus_i.halted};

   int checks = 0;
   int failures = 0;
   int act_lat, act_pcen, act_rfwe, act_wr, act_rd;
   logic [CNT_W-1:0] model_cnt;
   cyc_t trace[$];
   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic logic [3:0] rop();
      return 4'($urandom_range(0, 15));
   endfunction

   function automatic int op_class(input logic [3:0] op);
      if (op == 4'd0)        return K_NOP;
      else if (op <= 4'd7)   return K_ALU;
      else if (op == 4'd8)   return K_LD;
      else if (op == 4'd9)   return K_ST;
      else if (op == 4'd10)  return K_BEQ;
      else if (op == 4'd11)  return K_JMP;
      else if (op == 4'd15)  return K_HLT;
      else                   return K_NOP;
   endfunction

   task automatic push(input logic rdy, input logic zf, input logic [3:0] op,
                       input logic [2:0] st, input logic [8:0] o);
      cyc_t c;
      c.rdy = rdy; c.zf = zf; c.op = op; c.st = st; c.outs = o; c.ret = model_cnt;
      trace.push_back(c);
   endtask

   // Expected cycle-by-cycle trace of one instruction from the latency/strobe rules.
   task automatic build_instr(input logic [3:0] op, input int fw, input int mw, input logic zf);
      int k;
      logic [8:0] o;
      k = op_class(op);
      for (int i = 0; i < fw; i++) push(1'b0, rb(), rop(), 3'd0, O_RD);
      push(1'b1, rb(), rop(), 3'd0, O_RD | O_IREN | O_PCEN);
      push(rb(), rb(), op, 3'd1, 9'd0);
      if (k == K_NOP || k == K_HLT) begin
         model_cnt = model_cnt + 1'b1;
         return;
      end
      if (k == K_BEQ)      push(rb(), zf, op, 3'd2, O_PCSEL | (zf ? O_PCEN : 9'd0));
      else if (k == K_JMP) push(rb(), rb(), op, 3'd2, O_PCSEL | O_PCEN);
      else                 push(rb(), rb(), op, 3'd2, 9'd0);
      if (k == K_LD || k == K_ST) begin
         o = O_ADDR | ((k == K_LD) ? O_RD : O_WR);
         for (int i = 0; i < mw; i++) push(1'b0, rb(), op, 3'd3, o);
         push(1'b1, rb(), op, 3'd3, o);
      end
      if (k == K_ALU || k == K_LD) push(rb(), rb(), op, 3'd4, O_RFWE | ((k == K_LD) ? O_WBSEL : 9'd0));
      model_cnt = model_cnt + 1'b1;
   endtask

   task automatic run_trace(input string tag);
      cyc_t c;
      while (trace.size() > 0) begin
         c = trace.pop_front();
         @(negedge clk);
         bus_i.mem_ready = c.rdy;
         bus_i.zero_flag = c.zf;
         bus_i.opcode    = c.op;
         #1;
         check({tag, " state"},   32'(bus_i.state),   32'(c.st));
         check({tag, " outs"},    32'(outs_w),        32'(c.outs));
         check({tag, " retired"}, 32'(bus_i.retired), 32'(c.ret));
         if (bus_i.state != 3'd0 || bus_i.mem_rd) act_lat++;
         if (bus_i.pc_en)  act_pcen++;
         if (bus_i.rf_we)  act_rfwe++;
         if (bus_i.mem_wr) act_wr++;
         if (bus_i.mem_rd) act_rd++;
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bus_i.mem_ready = 1'b1;
      #1;
      check("reset strobes", 32'(outs_w & ~O_HALT), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      bus_i.mem_ready = 1'b0;
      #1;
      check("reset state",   32'(bus_i.state),   32'd0);
      check("reset retired", 32'(bus_i.retired), 32'd0);
      check("reset halted",  32'(bus_i.halted),  32'd0);
      model_cnt = '0;
   endtask

   initial begin
      vecs[0] = '{op: 4'h0, fw: 0, mw: 0, zf: 1'b0, lat: 2, pcen: 1, rfwe: 0, wr: 0, rd: 1};
      vecs[1] = '{op: 4'h3, fw: 3, mw: 0, zf: 1'b0, lat: 7, pcen: 1, rfwe: 1, wr: 0, rd: 4};
      vecs[2] = '{op: 4'h8, fw: 0, mw: 2, zf: 1'b0, lat: 7, pcen: 1, rfwe: 1, wr: 0, rd: 4};
      vecs[3] = '{op: 4'h9, fw: 0, mw: 0, zf: 1'b0, lat: 4, pcen: 1, rfwe: 0, wr: 1, rd: 1};
      vecs[4] = '{op: 4'hA, fw: 0, mw: 0, zf: 1'b0, lat: 3, pcen: 1, rfwe: 0, wr: 0, rd: 1};
      vecs[5] = '{op: 4'hA, fw: 0, mw: 0, zf: 1'b1, lat: 3, pcen: 2, rfwe: 0, wr: 0, rd: 1};
      vecs[6] = '{op: 4'hB, fw: 0, mw: 0, zf: 1'b0, lat: 3, pcen: 2, rfwe: 0, wr: 0, rd: 1};
      vecs[7] = '{op: 4'hC, fw: 0, mw: 0, zf: 1'b0, lat: 2, pcen: 1, rfwe: 0, wr: 0, rd: 1};
      vecs[8] = '{op: 4'h7, fw: 1, mw: 0, zf: 1'b0, lat: 5, pcen: 1, rfwe: 1, wr: 0, rd: 2};
      vecs[9] = '{op: 4'h9, fw: 1, mw: 3, zf: 1'b0, lat: 8, pcen: 1, rfwe: 0, wr: 4, rd: 2};

      reset = 1'b1;
      bus_i.opcode = 4'd0;
      bus_i.zero_flag = 1'b0;
      bus_i.mem_ready = 1'b0;
      model_cnt = '0;
      do_reset();

      for (int v = 0; v < 10; v++) begin
         act_lat = 0; act_pcen = 0; act_rfwe = 0; act_wr = 0; act_rd = 0;
         build_instr(vecs[v].op, vecs[v].fw, vecs[v].mw, vecs[v].zf);
         run_trace($sformatf("vec%0d", v));
         check($sformatf("vec%0d latency", v), 32'(act_lat),  32'(vecs[v].lat));
         check($sformatf("vec%0d pc_en", v),   32'(act_pcen), 32'(vecs[v].pcen));
         check($sformatf("vec%0d rf_we", v),   32'(act_rfwe), 32'(vecs[v].rfwe));
         check($sformatf("vec%0d mem_wr", v),  32'(act_wr),   32'(vecs[v].wr));
         check($sformatf("vec%0d mem_rd", v),  32'(act_rd),   32'(vecs[v].rd));
      end

      for (int n = 0; n < 300; n++) begin
         build_instr(4'($urandom_range(0, 14)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), rb());
         run_trace("rand");
      end

      // HLT: one retire, then parked in HALT until reset
      build_instr(4'hF, 1, 0, 1'b0);
      for (int i = 0; i < 12; i++) push(rb(), rb(), rop(), 3'd5, O_HALT);
      run_trace("halt");
      do_reset();

      // Reset while an LD waits in MEM
      build_instr(4'h8, 0, 3, 1'b0);
      while (trace.size() > 4) void'(trace.pop_back());
      run_trace("ld_abort");
      do_reset();
      build_instr(4'h0, 0, 0, 1'b0);
      run_trace("post_abort");

      // Counter wrap
      do_reset();
      for (int i = 0; i < 1023; i++) begin
         build_instr(4'h0, 0, 0, rb());
         run_trace("fill");
      end
      @(negedge clk);
      bus_i.mem_ready = 1'b0;
      #1;
      check("pre-wrap retired", 32'(bus_i.retired), 32'(CNT_MAX));
      build_instr(4'h0, 0, 0, 1'b0);
      run_trace("wrap");
      @(negedge clk);
      bus_i.mem_ready = 1'b0;
      #1;
      check("wrap retired", 32'(bus_i.retired), 32'd0);
      check("wrap state",   32'(bus_i.state),   32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
